ar_arbiter_s: RTL and testbench

//  Read-address (AR) arbiter for one AXI slave port. Shares that slave among masters M0..M2.
//  - Picks one requester round-robin and registers its AR beat.
//  - Forwards the beat with a 4-bit master tag prepended to ARID (M0=4'b0001, M1=4'b0010, M2=4'b0011).
//  - Blocks further grants until the burst's RLAST handshake; the R-channel ID decoder then routes data by that tag.

---
 rtl/axi_arb_pkg.sv | 36 +++
 rtl/ar_arbiter_s_if.sv | 44 ++++
 rtl/rr_pick3.sv | 29 ++
 rtl/ar_arbiter_s.sv | 134 +++++++++++++
 tb/tb_ar_arbiter_s.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_arb_pkg.sv
// rtl/axi_arb_pkg.sv - shared types and master tags for the AR arbiter
package axi_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } ar_state_e;

    localparam logic [3:0] TAG_M0  = 4'b0001;
    localparam logic [3:0] TAG_M1  = 4'b0010;
    localparam logic [3:0] TAG_M2  = 4'b0011;
    localparam logic [3:0] TAG_DEF = 4'b0000;

    localparam int ARB_AW  = 32;
    localparam int ARB_IDW = 4;

    // id already carries the master tag in its top nibble
    typedef struct packed {
        logic [ARB_AW-1:0]    addr;
        logic [ARB_IDW+3:0]   id;
        logic [3:0]           len;
        logic [2:0]           size;
        logic [1:0]           burst;
    } ar_beat_t;

    function automatic logic [3:0] master_tag(input logic [1:0] idx);
        case (idx)
            2'd0:    master_tag = TAG_M0;
            2'd1:    master_tag = TAG_M1;
            2'd2:    master_tag = TAG_M2;
            default: master_tag = TAG_DEF;
        endcase
    endfunction

endpackage

// File: rtl/ar_arbiter_s_if.sv
// rtl/ar_arbiter_s_if.sv - AR request bus from three masters plus the shared slave AR/R observe signals
interface ar_arbiter_s_if #(
    parameter int AW  = 32,
    parameter int IDW = 4
) ();

    logic [2:0]       ARVALID_M;
    logic [2:0]       ARREADY_M;
    logic [3*IDW-1:0] ARID_M;
    logic [3*AW-1:0]  ARADDR_M;
    logic [11:0]      ARLEN_M;
    logic [8:0]       ARSIZE_M;
    logic [5:0]       ARBURST_M;

    logic             ARVALID_S;
    logic             ARREADY_S;
    logic [IDW+3:0]   ARID_S;
    logic [AW-1:0]    ARADDR_S;
    logic [3:0]       ARLEN_S;
    logic [2:0]       ARSIZE_S;
    logic [1:0]       ARBURST_S;

    logic             RVALID_S;
    logic             RREADY_S;
    logic             RLAST_S;

    // slave: the arbiter; master: the requesting masters and the shared slave
    modport slave (
        input  ARVALID_M, ARID_M, ARADDR_M, ARLEN_M, ARSIZE_M, ARBURST_M,
        output ARREADY_M,
        output ARVALID_S, ARID_S, ARADDR_S, ARLEN_S, ARSIZE_S, ARBURST_S,
        input  ARREADY_S,
        input  RVALID_S, RREADY_S, RLAST_S
    );

    modport master (
        output ARVALID_M, ARID_M, ARADDR_M, ARLEN_M, ARSIZE_M, ARBURST_M,
        input  ARREADY_M,
        input  ARVALID_S, ARID_S, ARADDR_S, ARLEN_S, ARSIZE_S, ARBURST_S,
        output ARREADY_S,
        output RVALID_S, RREADY_S, RLAST_S
    );

endinterface

// File: rtl/rr_pick3.sv
// rtl/rr_pick3.sv - combinational 3-way round-robin pick, ptr names the highest-priority requester
module rr_pick3 (
    input  logic [2:0] req,
    input  logic [1:0] ptr,
    output logic [2:0] gnt
);

    always_comb begin
        gnt = 3'b000;
        case (ptr)
            2'd1: begin
                if      (req[1]) gnt = 3'b010;
                else if (req[2]) gnt = 3'b100;
                else if (req[0]) gnt = 3'b001;
            end
            2'd2: begin
                if      (req[2]) gnt = 3'b100;
                else if (req[0]) gnt = 3'b001;
                else if (req[1]) gnt = 3'b010;
            end
            default: begin
                if      (req[0]) gnt = 3'b001;
                else if (req[1]) gnt = 3'b010;
                else if (req[2]) gnt = 3'b100;
            end
        endcase
    end

endmodule

// File: rtl/ar_arbiter_s.sv
// rtl/ar_arbiter_s.sv - round-robin AR arbiter, one outstanding read per slave; AXI_ARB_WDOG_EN adds a watchdog
module ar_arbiter_s
    import axi_arb_pkg::*;
#(
    parameter int AW      = ARB_AW,
    parameter int IDW     = ARB_IDW,
    parameter int WDOG_CY = 255
) (
    input  logic          ACLK,
    input  logic          ARESETn,
    ar_arbiter_s_if.slave bus,
    output logic          busy,
    output logic          wdog_err
);

    ar_state_e      state_q, state_d;
    logic [1:0]     rr_ptr;
    logic [2:0]     gnt;
    logic [1:0]     win_idx;
    logic           grant;
    logic           r_last_hs;
    logic           wdog_fire;
    logic           arvalid_q;
    ar_beat_t       beat_q, beat_d;

    logic [AW-1:0]  sel_addr;
    logic [IDW-1:0] sel_id;
    logic [3:0]     sel_len;
    logic [2:0]     sel_size;
    logic [1:0]     sel_burst;

    rr_pick3 u_pick (
        .req (bus.ARVALID_M),
        .ptr (rr_ptr),
        .gnt (gnt)
    );

    assign grant     = (state_q == IDLE) && (|gnt);
    assign r_last_hs = bus.RVALID_S & bus.RREADY_S & bus.RLAST_S;

    always_comb begin
        win_idx   = 2'd0;
        sel_addr  = bus.ARADDR_M[0 +: AW];
        sel_id    = bus.ARID_M[0 +: IDW];
        sel_len   = bus.ARLEN_M[0 +: 4];
        sel_size  = bus.ARSIZE_M[0 +: 3];
        sel_burst = bus.ARBURST_M[0 +: 2];
        for (int k = 0; k < 3; k++) begin
            if (gnt[k]) begin
                win_idx   = 2'(k);
                sel_addr  = bus.ARADDR_M[k*AW +: AW];
                sel_id    = bus.ARID_M[k*IDW +: IDW];
                sel_len   = bus.ARLEN_M[k*4 +: 4];
                sel_size  = bus.ARSIZE_M[k*3 +: 3];
                sel_burst = bus.ARBURST_M[k*2 +: 2];
            end
        end
    end

    always_comb begin
        beat_d       = beat_q;
        beat_d.addr  = ARB_AW'(sel_addr);
        beat_d.id    = (ARB_IDW+4)'({master_tag(win_idx), sel_id});
        beat_d.len   = sel_len;
        beat_d.size  = sel_size;
        beat_d.burst = sel_burst;
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant)         state_d = ADDR;
            ADDR:    if (bus.ARREADY_S) state_d = DATA;
            DATA:    if (r_last_hs)     state_d = IDLE;
            default:                    state_d = IDLE;
        endcase
        if (wdog_fire) state_d = IDLE;
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            rr_ptr    <= 2'd0;
            arvalid_q <= 1'b0;
            beat_q    <= '0;
        end else begin
            arvalid_q <= (state_d == ADDR);
            if (grant) begin
                beat_q <= beat_d;
                rr_ptr <= (win_idx == 2'd2) ? 2'd0 : win_idx + 2'd1;
            end
        end
    end

`ifdef AXI_ARB_WDOG_EN
    logic [7:0] wdog_cnt;
    logic       wdog_err_q;

    // fires on the WDOG_CY-th edge after the grant
    assign wdog_fire = (state_q != IDLE) && (wdog_cnt == 8'(WDOG_CY - 1));

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            wdog_cnt   <= 8'd0;
            wdog_err_q <= 1'b0;
        end else begin
            if (grant)                  wdog_cnt <= 8'd0;
            else if (state_q != IDLE)   wdog_cnt <= wdog_cnt + 8'd1;
            if (wdog_fire)              wdog_err_q <= 1'b1;
        end
    end

    assign wdog_err = wdog_err_q;
`else
    logic [7:0] unused_wdog_cy;
    assign unused_wdog_cy = 8'(WDOG_CY);
    assign wdog_fire      = 1'b0;
    assign wdog_err       = 1'b0;
`endif

    assign bus.ARREADY_M = (state_q == IDLE) ? gnt : 3'b000;
    assign bus.ARVALID_S = arvalid_q;
    assign bus.ARID_S    = (IDW+4)'(beat_q.id);
    assign bus.ARADDR_S  = AW'(beat_q.addr);
    assign bus.ARLEN_S   = beat_q.len;
    assign bus.ARSIZE_S  = beat_q.size;
    assign bus.ARBURST_S = beat_q.burst;
    assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_ar_arbiter_s.sv
// tb/tb_ar_arbiter_s.sv - table-driven bench with an AR beat scoreboard for ar_arbiter_s
module tb_ar_arbiter_s;

    localparam int AW  = 32;
    localparam int IDW = 4;

    logic ACLK    = 1'b0;
    logic ARESETn = 1'b0;
    logic busy;
    logic wdog_err;

    ar_arbiter_s_if #(.AW(AW), .IDW(IDW)) bus ();

    ar_arbiter_s #(.AW(AW), .IDW(IDW), .WDOG_CY(16)) dut (
        .ACLK     (ACLK),
        .ARESETn  (ARESETn),
        .bus      (bus),
        .busy     (busy),
        .wdog_err (wdog_err)
    );

    always #5 ACLK = ~ACLK;

    typedef struct {
        logic [2:0]     req;
        logic [2:0]     gnt;
        logic [AW-1:0]  addr;
        logic [IDW-1:0] id;
        logic [3:0]     len;
        int             stall;
    } vec_t;

    typedef struct {
        logic [IDW+3:0] id;
        logic [AW-1:0]  addr;
        logic [3:0]     len;
        logic [2:0]     size;
        logic [1:0]     burst;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // master k presents addr ^ {k,28'h0}, id ^ k, size k+1, burst k
    task automatic drive_masters(input vec_t v);
        for (int k = 0; k < 3; k++) begin
            bus.ARID_M[k*IDW +: IDW]  = v.id ^ IDW'(k);
            bus.ARADDR_M[k*AW +: AW]  = v.addr ^ {4'(k), 28'h0};
            bus.ARLEN_M[k*4 +: 4]     = v.len;
            bus.ARSIZE_M[k*3 +: 3]    = 3'(k + 1);
            bus.ARBURST_M[k*2 +: 2]   = 2'(k);
        end
    endtask

    task automatic clear_r();
        bus.RVALID_S = 1'b0;
        bus.RREADY_S = 1'b0;
        bus.RLAST_S  = 1'b0;
    endtask

    task automatic run_rec(input vec_t v, input int idx);
        exp_t e;
        exp_t got;
        int   w;
        @(negedge ACLK);
        clear_r();
        drive_masters(v);
        bus.ARVALID_M = v.req;
        #1;
        check($sformatf("v%0d arready_m", idx), 64'(bus.ARREADY_M), 64'(v.gnt));
        if (v.gnt == 3'b000) begin
            bus.RVALID_S = 1'b1;
            bus.RREADY_S = 1'b1;
            bus.RLAST_S  = 1'b1;
            @(posedge ACLK); #1;
            check($sformatf("v%0d idle_busy", idx), 64'(busy), 64'(0));
            check($sformatf("v%0d idle_arvalid_s", idx), 64'(bus.ARVALID_S), 64'(0));
            bus.ARVALID_M = 3'b000;
            return;
        end
        w = v.gnt[0] ? 0 : (v.gnt[1] ? 1 : 2);
        e.id    = {4'(w + 1), v.id ^ IDW'(w)};
        e.addr  = v.addr ^ {4'(w), 28'h0};
        e.len   = v.len;
        e.size  = 3'(w + 1);
        e.burst = 2'(w);
        sb_q.push_back(e);
        @(posedge ACLK); #1;
        bus.ARVALID_M = 3'b000;
        check($sformatf("v%0d arvalid_s_set", idx), 64'(bus.ARVALID_S), 64'(1));
        for (int s = 0; s < v.stall; s++) begin
            @(negedge ACLK);
            bus.ARVALID_M = ~v.gnt;
            bus.RVALID_S  = 1'b1;
            bus.RREADY_S  = 1'b1;
            bus.RLAST_S   = 1'b1;
            #1;
            check($sformatf("v%0d stall%0d arready_m", idx, s), 64'(bus.ARREADY_M), 64'(0));
            check($sformatf("v%0d stall%0d arvalid_s", idx, s), 64'(bus.ARVALID_S), 64'(1));
            check($sformatf("v%0d stall%0d araddr_s", idx, s), 64'(bus.ARADDR_S), 64'(e.addr));
            check($sformatf("v%0d stall%0d arid_s", idx, s), 64'(bus.ARID_S), 64'(e.id));
        end
        @(negedge ACLK);
        bus.ARVALID_M = 3'b000;
        clear_r();
        bus.ARREADY_S = 1'b1;
        #1;
        if (sb_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL v%0d scoreboard: got empty queue want one beat", idx);
        end else begin
            got = sb_q.pop_front();
            check($sformatf("v%0d hs_arvalid_s", idx), 64'(bus.ARVALID_S), 64'(1));
            check($sformatf("v%0d arid_s", idx), 64'(bus.ARID_S), 64'(got.id));
            check($sformatf("v%0d araddr_s", idx), 64'(bus.ARADDR_S), 64'(got.addr));
            check($sformatf("v%0d arlen_s", idx), 64'(bus.ARLEN_S), 64'(got.len));
            check($sformatf("v%0d arsize_s", idx), 64'(bus.ARSIZE_S), 64'(got.size));
            check($sformatf("v%0d arburst_s", idx), 64'(bus.ARBURST_S), 64'(got.burst));
        end
        @(posedge ACLK); #1;
        bus.ARREADY_S = 1'b0;
        check($sformatf("v%0d arvalid_s_clr", idx), 64'(bus.ARVALID_S), 64'(0));
        check($sformatf("v%0d data_busy", idx), 64'(busy), 64'(1));
        for (int b = 0; b <= int'(v.len); b++) begin
            @(negedge ACLK);
            bus.RVALID_S  = 1'b1;
            bus.RREADY_S  = 1'b1;
            bus.RLAST_S   = (b == int'(v.len));
            bus.ARVALID_M = (b == int'(v.len)) ? 3'b000 : 3'b111;
            #1;
            check($sformatf("v%0d beat%0d arready_m", idx, b), 64'(bus.ARREADY_M), 64'(0));
            check($sformatf("v%0d beat%0d busy", idx, b), 64'(busy), 64'(1));
            @(posedge ACLK); #1;
        end
        check($sformatf("v%0d rlast_idle", idx), 64'(busy), 64'(0));
    endtask

    initial begin
        vec_t vt[12];
        vec_t hv;

        bus.ARVALID_M = 3'b000;
        bus.ARID_M    = '0;
        bus.ARADDR_M  = '0;
        bus.ARLEN_M   = '0;
        bus.ARSIZE_M  = '0;
        bus.ARBURST_M = '0;
        bus.ARREADY_S = 1'b0;
        clear_r();

        repeat (3) @(posedge ACLK);
        @(negedge ACLK); #1;
        check("reset busy", 64'(busy), 64'(0));
        check("reset arvalid_s", 64'(bus.ARVALID_S), 64'(0));
        check("reset arid_s", 64'(bus.ARID_S), 64'(0));
        check("reset araddr_s", 64'(bus.ARADDR_S), 64'(0));
        check("reset wdog_err", 64'(wdog_err), 64'(0));
        @(negedge ACLK);
        ARESETn = 1'b1;

        //         req     gnt     addr          id    len   stall
        vt[0]  = '{3'b111, 3'b001, 32'h0000_0100, 4'h1, 4'd0, 0};
        vt[1]  = '{3'b111, 3'b010, 32'h0000_0200, 4'h2, 4'd1, 1};
        vt[2]  = '{3'b111, 3'b100, 32'h0000_0300, 4'h3, 4'd2, 0};
        vt[3]  = '{3'b111, 3'b001, 32'h0000_0400, 4'h6, 4'd0, 2};
        vt[4]  = '{3'b010, 3'b010, 32'h0000_0040, 4'h4, 4'd0, 0};
        vt[5]  = '{3'b000, 3'b000, 32'h0000_0500, 4'h0, 4'd0, 0};
        vt[6]  = '{3'b011, 3'b001, 32'h0000_0600, 4'h9, 4'd3, 5};
        vt[7]  = '{3'b101, 3'b100, 32'h0000_0700, 4'hA, 4'd1, 0};
        vt[8]  = '{3'b110, 3'b010, 32'h0000_0800, 4'hB, 4'd2, 1};
        vt[9]  = '{3'b001, 3'b001, 32'h0000_0900, 4'hC, 4'd0, 0};
        vt[10] = '{3'b100, 3'b100, 32'h0000_0A00, 4'hD, 4'd1, 3};
        vt[11] = '{3'b011, 3'b001, 32'h0000_0B00, 4'hE, 4'd0, 0};

        for (int i = 0; i < 12; i++) run_rec(vt[i], i);

        // asynchronous reset while waiting for RLAST
        hv = '{3'b001, 3'b001, 32'h0000_0C00, 4'h7, 4'd3, 0};
        @(negedge ACLK);
        drive_masters(hv);
        bus.ARVALID_M = hv.req;
        #1;
        check("rst_seq arready_m", 64'(bus.ARREADY_M), 64'(3'b001));
        @(posedge ACLK); #1;
        bus.ARVALID_M = 3'b000;
        bus.ARREADY_S = 1'b1;
        @(posedge ACLK); #1;
        bus.ARREADY_S = 1'b0;
        check("rst_seq in_data busy", 64'(busy), 64'(1));
        @(negedge ACLK);
        ARESETn = 1'b0;
        #1;
        check("rst_seq busy", 64'(busy), 64'(0));
        check("rst_seq arvalid_s", 64'(bus.ARVALID_S), 64'(0));
        check("rst_seq arid_s", 64'(bus.ARID_S), 64'(0));
        check("rst_seq araddr_s", 64'(bus.ARADDR_S), 64'(0));
        @(negedge ACLK);
        ARESETn = 1'b1;
        sb_q.delete();
        run_rec('{3'b111, 3'b001, 32'h0000_0D00, 4'h8, 4'd0, 0}, 100);

        // slave never accepts the AR beat
        hv = '{3'b010, 3'b010, 32'h0000_0E00, 4'h1, 4'd0, 0};
        @(negedge ACLK);
        drive_masters(hv);
        bus.ARVALID_M = hv.req;
        #1;
        check("wdog_seq arready_m", 64'(bus.ARREADY_M), 64'(3'b010));
        @(posedge ACLK); #1;
        bus.ARVALID_M = 3'b000;
        repeat (20) @(posedge ACLK);
        #1;
`ifdef AXI_ARB_WDOG_EN
        check("wdog_seq wdog_err", 64'(wdog_err), 64'(1));
        check("wdog_seq busy", 64'(busy), 64'(0));
        check("wdog_seq arvalid_s", 64'(bus.ARVALID_S), 64'(0));
`else
        check("wdog_seq wdog_err", 64'(wdog_err), 64'(0));
        check("wdog_seq busy", 64'(busy), 64'(1));
        check("wdog_seq arvalid_s", 64'(bus.ARVALID_S), 64'(1));
`endif
        @(negedge ACLK);
        ARESETn = 1'b0;
        #1;
        check("final reset wdog_err", 64'(wdog_err), 64'(0));
        @(negedge ACLK);
        ARESETn = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
